// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the two-requester stack arbiter.
// State encoding, op codes and default widths live here.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    POPWAIT = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 32;
  localparam int CW_DEF    = 6;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester, stack and status signals of the stack arbiter.
// master = requesters plus stack, slave = the arbiter.
interface stack_arbiter_if #(
  parameter int DW = 8,
  parameter int CW = 6
);

  logic          Req_A;
  logic          Op_A;
  logic [DW-1:0] Wdata_A;
  logic          Ack_A;
  logic          Err_A;
  logic [DW-1:0] Rdata_A;

  logic          Req_B;
  logic          Op_B;
  logic [DW-1:0] Wdata_B;
  logic          Ack_B;
  logic          Err_B;
  logic [DW-1:0] Rdata_B;

  logic          St_Push;
  logic          St_Pop;
  logic [DW-1:0] St_Din;
  logic [DW-1:0] St_Dout;
  logic          St_RstN;

  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;

  modport master (
    output Req_A, Op_A, Wdata_A,
    output Req_B, Op_B, Wdata_B,
    output St_Dout,
    input  Ack_A, Err_A, Rdata_A,
    input  Ack_B, Err_B, Rdata_B,
    input  St_Push, St_Pop, St_Din, St_RstN,
    input  Count, Full, Empty
  );

  modport slave (
    input  Req_A, Op_A, Wdata_A,
    input  Req_B, Op_B, Wdata_B,
    input  St_Dout,
    output Ack_A, Err_A, Rdata_A,
    output Ack_B, Err_B, Rdata_B,
    output St_Push, St_Pop, St_Din, St_RstN,
    output Count, Full, Empty
  );

endinterface

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin picker: grant 0 = A, 1 = B.
// On a tie the requester not served last wins.
module rr_arb2 (
  input  logic Req_A,
  input  logic Req_B,
  input  logic last_served,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (Req_A && Req_B):  grant = ~last_served;
      (Req_B && !Req_A): grant = 1'b1;
      default:           grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between requesters A and B.
// Sequences push/pop strobes and tracks occupancy locally.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input logic           Clk,
  input logic           Rst,
  stack_arbiter_if.slave bus
);

  localparam logic [CW-1:0] MAX = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state;
  logic          sel;
  logic          op_q;
  logic          last;
  logic [CW-1:0] count;
  logic          grant;
  logic          op_in;
  logic [DW-1:0] wd_in;
  logic          push_ok;
  logic          pop_ok;
  logic          in_ok;

  rr_arb2 u_arb (
    .Req_A       (bus.Req_A),
    .Req_B       (bus.Req_B),
    .last_served (last),
    .grant       (grant)
  );

  always_comb begin
    op_in   = grant ? bus.Op_B : bus.Op_A;
    wd_in   = grant ? bus.Wdata_B : bus.Wdata_A;
    push_ok = (op_q == OP_PUSH) && (count != MAX);
    pop_ok  = (op_q == OP_POP) && (count != '0);
    in_ok   = (op_in == OP_PUSH) ? (count != MAX)
                                 : (count != '0);
  end

  assign bus.Count   = count;
  assign bus.Full    = (count == MAX);
  assign bus.Empty   = (count == '0);
  assign bus.St_RstN = ~Rst;

  // Strobes are decided on entry to ISSUE so they are registered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      sel         <= ID_A;
      op_q        <= OP_POP;
      last        <= ID_B;
      count       <= '0;
      bus.Ack_A   <= 1'b0;
      bus.Ack_B   <= 1'b0;
      bus.Err_A   <= 1'b0;
      bus.Err_B   <= 1'b0;
      bus.Rdata_A <= '0;
      bus.Rdata_B <= '0;
      bus.St_Push <= 1'b0;
      bus.St_Pop  <= 1'b0;
      bus.St_Din  <= '0;
    end else begin
      bus.Ack_A   <= 1'b0;
      bus.Ack_B   <= 1'b0;
      bus.Err_A   <= 1'b0;
      bus.Err_B   <= 1'b0;
      bus.St_Push <= 1'b0;
      bus.St_Pop  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Req_A || bus.Req_B) begin
            sel  <= grant;
            op_q <= op_in;
            if (op_in == OP_PUSH) begin
              bus.St_Din <= wd_in;
            end
            bus.St_Push <= (op_in == OP_PUSH) && in_ok;
            bus.St_Pop  <= (op_in == OP_POP) && in_ok;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          unique case (1'b1)
            push_ok: begin
              count     <= count + ONE;
              bus.Ack_A <= (sel == ID_A);
              bus.Ack_B <= (sel == ID_B);
              state     <= ACK;
            end
            pop_ok: begin
              count <= count - ONE;
              state <= POPWAIT;
            end
            default: begin
              bus.Ack_A <= (sel == ID_A);
              bus.Ack_B <= (sel == ID_B);
              bus.Err_A <= (sel == ID_A);
              bus.Err_B <= (sel == ID_B);
              state     <= ACK;
            end
          endcase
        end
        POPWAIT: begin
          if (sel == ID_B) begin
            bus.Rdata_B <= bus.St_Dout;
          end else begin
            bus.Rdata_A <= bus.St_Dout;
          end
          bus.Ack_A <= (sel == ID_A);
          bus.Ack_B <= (sel == ID_B);
          state     <= ACK;
        end
        ACK: begin
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural LIFO.
// Inputs change and outputs are sampled on the falling edge.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  logic Clk;
  logic Rst;

  stack_arbiter_if #(.DW(8), .CW(6)) bus ();

  stack_arbiter dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] mem [32];
  int sp = 0;

  always @(posedge Clk or negedge bus.St_RstN) begin
    if (!bus.St_RstN) begin
      sp          <= 0;
      bus.St_Dout <= 8'h00;
    end else if (bus.St_Push && sp < 32) begin
      mem[sp] <= bus.St_Din;
      sp      <= sp + 1;
    end else if (bus.St_Pop && sp > 0) begin
      bus.St_Dout <= mem[sp-1];
      sp          <= sp - 1;
    end
  end

  int push_cnt = 0;
  int pop_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] last_din = 8'h00;

  always @(negedge Clk) begin
    if (bus.St_Push) begin
      push_cnt++;
      last_din = bus.St_Din;
    end
    if (bus.St_Pop) pop_cnt++;
    if (bus.St_Push && bus.St_Pop) both_cnt++;
  end

  int checks = 0;
  int errors = 0;

  logic       ord [8];
  logic [7:0] dat [8];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_rstn", 32'(bus.St_RstN), 0);
    Rst = 1'b0;
  endtask

  task automatic do_req(input logic id, input logic op,
                        input logic [7:0] d,
                        input logic exp_err,
                        input logic [7:0] exp_rd,
                        input int exp_lat,
                        input string tag);
    int  p0, q0, lat;
    logic got, ack;
    @(negedge Clk);
    p0 = push_cnt;
    q0 = pop_cnt;
    if (id) begin
      bus.Req_B = 1'b1; bus.Op_B = op; bus.Wdata_B = d;
    end else begin
      bus.Req_A = 1'b1; bus.Op_A = op; bus.Wdata_A = d;
    end
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge Clk);
      ack = id ? bus.Ack_B : bus.Ack_A;
      if (ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk({tag, "_ack"}, 32'(got), 1);
    if (got) begin
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"},
          32'(id ? bus.Err_B : bus.Err_A), 32'(exp_err));
      if (!op && !exp_err)
        chk({tag, "_rdata"},
            32'(id ? bus.Rdata_B : bus.Rdata_A), 32'(exp_rd));
    end
    if (id) bus.Req_B = 1'b0;
    else    bus.Req_A = 1'b0;
    chk({tag, "_npush"}, 32'(push_cnt - p0),
        32'(op && !exp_err));
    chk({tag, "_npop"}, 32'(pop_cnt - q0),
        32'(!op && !exp_err));
    if (op && !exp_err)
      chk({tag, "_din"}, 32'(last_din), 32'(d));
  endtask

  task automatic pair(input logic oa, input logic [7:0] da,
                      input logic ob, input logic [7:0] db,
                      input int n, input logic hold,
                      input string tag);
    int k;
    @(negedge Clk);
    bus.Req_A = 1'b1; bus.Op_A = oa; bus.Wdata_A = da;
    bus.Req_B = 1'b1; bus.Op_B = ob; bus.Wdata_B = db;
    k = 0;
    for (int i = 0; i < 60 && k < n; i++) begin
      @(negedge Clk);
      if (bus.Ack_A) begin
        ord[k] = 1'b0; dat[k] = bus.Rdata_A; k++;
        if (!hold) bus.Req_A = 1'b0;
      end
      if (bus.Ack_B) begin
        ord[k] = 1'b1; dat[k] = bus.Rdata_B; k++;
        if (!hold) bus.Req_B = 1'b0;
      end
    end
    bus.Req_A = 1'b0;
    bus.Req_B = 1'b0;
    chk({tag, "_nacks"}, 32'(k), 32'(n));
  endtask

  initial begin
    Rst = 1'b1;
    bus.Req_A = 0; bus.Op_A = 0; bus.Wdata_A = 0;
    bus.Req_B = 0; bus.Op_B = 0; bus.Wdata_B = 0;
    repeat (2) @(negedge Clk);
    chk("rst_count", 32'(bus.Count), 0);
    chk("rst_empty", 32'(bus.Empty), 1);
    chk("rst_full", 32'(bus.Full), 0);
    chk("rst_ack", 32'({bus.Ack_A, bus.Ack_B}), 0);
    chk("rst_strobe", 32'({bus.St_Push, bus.St_Pop}), 0);
    chk("rst_rdata", 32'({bus.Rdata_A, bus.Rdata_B}), 0);
    chk("rst_din", 32'(bus.St_Din), 0);
    chk("rst_rstn", 32'(bus.St_RstN), 0);
    Rst = 1'b0;

    do_req(ID_A, OP_PUSH, 8'h11, 1'b0, 8'h00, 2, "t1_push");
    chk("t1_count", 32'(bus.Count), 1);

    reset_dut();
    pair(OP_PUSH, 8'h22, OP_PUSH, 8'h33, 2, 1'b0, "t2");
    chk("t2_first", 32'(ord[0]), 0);
    chk("t2_second", 32'(ord[1]), 1);
    chk("t2_count", 32'(bus.Count), 2);
    do_req(ID_B, OP_POP, 8'h00, 1'b0, 8'h33, 3, "t2_pop_b");
    do_req(ID_A, OP_POP, 8'h00, 1'b0, 8'h22, 3, "t2_pop_a");

    do_req(ID_B, OP_POP, 8'h00, 1'b1, 8'h00, 2, "t3_empty");
    chk("t3_count", 32'(bus.Count), 0);
    chk("t3_empty", 32'(bus.Empty), 1);
    chk("t3_hold", 32'(bus.Rdata_B), 32'h33);

    for (int i = 0; i < 32; i++)
      do_req(ID_A, OP_PUSH, 8'(i), 1'b0, 8'h00, 2, "t4_fill");
    chk("t4_full", 32'(bus.Full), 1);
    chk("t4_count", 32'(bus.Count), 32);
    do_req(ID_A, OP_PUSH, 8'hFF, 1'b1, 8'h00, 2, "t4_over_a");
    do_req(ID_B, OP_PUSH, 8'hEE, 1'b1, 8'h00, 2, "t4_over_b");
    chk("t4_count2", 32'(bus.Count), 32);

    pair(OP_POP, 8'h00, OP_POP, 8'h00, 4, 1'b1, "t5");
    chk("t5_ord0", 32'(ord[0]), 0);
    chk("t5_ord1", 32'(ord[1]), 1);
    chk("t5_ord2", 32'(ord[2]), 0);
    chk("t5_ord3", 32'(ord[3]), 1);
    chk("t5_dat0", 32'(dat[0]), 32'h1F);
    chk("t5_dat1", 32'(dat[1]), 32'h1E);
    chk("t5_dat2", 32'(dat[2]), 32'h1D);
    chk("t5_dat3", 32'(dat[3]), 32'h1C);
    chk("t5_count", 32'(bus.Count), 28);

    @(negedge Clk);
    @(negedge Clk);
    bus.Req_A = 1'b1; bus.Op_A = OP_POP; bus.Wdata_A = 8'h00;
    @(negedge Clk);
    chk("t6_issue", 32'(dut.state), 32'(ISSUE));
    @(negedge Clk);
    chk("t6_popwait", 32'(dut.state), 32'(POPWAIT));
    Rst = 1'b1;
    #1;
    chk("t6_state", 32'(dut.state), 32'(IDLE));
    chk("t6_count", 32'(bus.Count), 0);
    chk("t6_rstn", 32'(bus.St_RstN), 0);
    chk("t6_rdata", 32'(bus.Rdata_A), 0);
    bus.Req_A = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("t6_noack", 32'({bus.Ack_A, bus.Ack_B}), 0);
    end
    Rst = 1'b0;
    do_req(ID_A, OP_PUSH, 8'h44, 1'b0, 8'h00, 2, "t6_push");
    chk("t6_count1", 32'(bus.Count), 1);
    do_req(ID_A, OP_POP, 8'h00, 1'b0, 8'h44, 3, "t6_pop");
    chk("t6_count0", 32'(bus.Count), 0);

    chk("no_dual_strobe", 32'(both_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
